// File: rtl/fl_frame_marker_pkg.sv
// Shared types and constants for the FrameLink frame marker.
package fl_frame_marker_pkg;

  // Between frames (header decision) or inside a frame (pass-through).
  typedef enum logic {
    S_HDR  = 1'b0,
    S_BODY = 1'b1
  } state_e;

  // Header word field positions.
  localparam int unsigned ID_HI  = 31;
  localparam int unsigned ID_LO  = 16;
  localparam int unsigned SEQ_HI = 15;
  localparam int unsigned SEQ_LO = 0;

  // Byte-remainder width for a given data width.
  function automatic int unsigned rem_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/fl_frame_marker_if.sv
// FrameLink bus: data, remainder, active-low delimiters and handshake.
interface fl_frame_marker_if
  import fl_frame_marker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
);

  localparam int unsigned REM_WIDTH = rem_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data;
  logic [REM_WIDTH-1:0]  rem;
  logic                  sof_n;
  logic                  eof_n;
  logic                  sop_n;
  logic                  eop_n;
  logic                  src_rdy_n;
  logic                  dst_rdy_n;

  modport master (
    output data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    input  dst_rdy_n
  );

  modport slave (
    input  data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    output dst_rdy_n
  );

endinterface

// File: rtl/fl_frame_marker.sv
// Prepends a one-word header (ID + wrapping sequence number) to every frame
// and suppresses the SOF of the original frame. No register stage on data.
module fl_frame_marker
  import fl_frame_marker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [15:0] HDR_ID     = 16'hF1A6,
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  fl_frame_marker_if.slave  rx,
  fl_frame_marker_if.master tx,
  output logic              DROP,
  output logic [15:0]       SEQ
);

  state_e      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic        drop_q, drop_d;
  logic        mode_q, mode_d;  // 1: current frame was given a header

  // Next-state and combinational output multiplexer.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    mode_d       = mode_q;
    drop_d       = 1'b0;

    tx.data      = rx.data;
    tx.rem       = rx.rem;
    tx.sof_n     = rx.sof_n;
    tx.eof_n     = rx.eof_n;
    tx.sop_n     = rx.sop_n;
    tx.eop_n     = rx.eop_n;
    tx.src_rdy_n = 1'b1;
    rx.dst_rdy_n = 1'b1;

    case (state_q)
      S_HDR: begin
        if (!rx.src_rdy_n) begin
          if (rx.sof_n) begin
            // Orphan word outside a frame: swallow it.
            rx.dst_rdy_n = 1'b0;
            drop_d       = 1'b1;
          end else if (ENABLE) begin
            // Header word; the SOF word waits on RX until the header is taken.
            tx.data                = {DATA_WIDTH{1'b0}};
            tx.data[ID_HI:ID_LO]   = HDR_ID;
            tx.data[SEQ_HI:SEQ_LO] = seq_q;
            tx.rem                 = '1;
            tx.sof_n               = 1'b0;
            tx.sop_n               = 1'b0;
            tx.eop_n               = 1'b0;
            tx.eof_n               = 1'b1;
            tx.src_rdy_n           = 1'b0;
            if (!tx.dst_rdy_n) begin
              seq_d   = seq_q + 16'd1;
              mode_d  = 1'b1;
              state_d = S_BODY;
            end
          end else begin
            // Unmarked frame: plain pass-through.
            tx.src_rdy_n = 1'b0;
            rx.dst_rdy_n = tx.dst_rdy_n;
            if (!tx.dst_rdy_n) begin
              mode_d  = 1'b0;
              state_d = rx.eof_n ? S_BODY : S_HDR;
            end
          end
        end
      end

      S_BODY: begin
        if (mode_q) tx.sof_n = 1'b1;
        tx.src_rdy_n = rx.src_rdy_n;
        rx.dst_rdy_n = tx.dst_rdy_n;
        if (!rx.src_rdy_n && !tx.dst_rdy_n && !rx.eof_n) state_d = S_HDR;
      end

      default: state_d = S_HDR;
    endcase

    // Both handshakes are held off while in reset.
    if (RESET) begin
      tx.src_rdy_n = 1'b1;
      rx.dst_rdy_n = 1'b1;
    end
  end

  // State, sequence counter, mode latch and drop pulse registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_HDR;
      seq_q   <= SEQ_INIT;
      drop_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      mode_q  <= mode_d;
    end
  end

  assign DROP = drop_q;
  assign SEQ  = seq_q;

endmodule

// File: tb/tb_fl_frame_marker.sv
// Directed bench for fl_frame_marker with hand-computed expected beats.
module tb_fl_frame_marker;

  localparam int unsigned DW = 64;

  // Delimiter nibbles {sof_n, eof_n, sop_n, eop_n}.
  localparam logic [3:0] F_SOF  = 4'b0101;
  localparam logic [3:0] F_MID  = 4'b1111;
  localparam logic [3:0] F_EOF  = 4'b1010;
  localparam logic [3:0] F_ONE  = 4'b0000;
  localparam logic [3:0] F_HDR  = 4'b0100;
  localparam logic [3:0] F_SOFX = 4'b1101;  // SOF word with SOF suppressed
  localparam logic [3:0] F_ONEX = 4'b1000;  // single word with SOF suppressed

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  rem;
    logic [3:0]  flags;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        en2;
  logic        drop, drop2;
  logic [15:0] seq, seq2;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          n_drop   = 0;
  int          d0;
  beat_t       tx_q[$];
  beat_t       tx2_q[$];

  always #5 clk = ~clk;

  fl_frame_marker_if #(.DATA_WIDTH(DW)) rx_if ();
  fl_frame_marker_if #(.DATA_WIDTH(DW)) tx_if ();
  fl_frame_marker_if #(.DATA_WIDTH(DW)) rx2_if ();
  fl_frame_marker_if #(.DATA_WIDTH(DW)) tx2_if ();

  fl_frame_marker #(
    .DATA_WIDTH(DW),
    .HDR_ID    (16'hF1A6),
    .SEQ_INIT  (16'h0000)
  ) u_dut (
    .CLK   (clk),
    .RESET (rst),
    .ENABLE(enable),
    .rx    (rx_if),
    .tx    (tx_if),
    .DROP  (drop),
    .SEQ   (seq)
  );

  fl_frame_marker #(
    .DATA_WIDTH(DW),
    .HDR_ID    (16'hF1A6),
    .SEQ_INIT  (16'hFFFE)
  ) u_wrap (
    .CLK   (clk),
    .RESET (rst),
    .ENABLE(en2),
    .rx    (rx2_if),
    .tx    (tx2_if),
    .DROP  (drop2),
    .SEQ   (seq2)
  );

  // TX beat capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (!tx_if.src_rdy_n && !tx_if.dst_rdy_n)
      tx_q.push_back({tx_if.data, tx_if.rem, tx_if.sof_n, tx_if.eof_n, tx_if.sop_n,
                      tx_if.eop_n});
    if (!tx2_if.src_rdy_n && !tx2_if.dst_rdy_n)
      tx2_q.push_back({tx2_if.data, tx2_if.rem, tx2_if.sof_n, tx2_if.eof_n, tx2_if.sop_n,
                       tx2_if.eop_n});
    if (drop) n_drop++;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic [2:0] r, input logic [3:0] f);
    return {d, r, f};
  endfunction

  function automatic logic [63:0] hdr(input logic [15:0] s);
    return {32'h0, 16'hF1A6, s};
  endfunction

  // Hold the presented RX word until it is accepted (bounded), then release it.
  task automatic wait_rx_accept(input string tag);
    int n = 0;
    @(negedge clk);
    while (rx_if.dst_rdy_n && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_accept"}, 128'(rx_if.dst_rdy_n), 128'h0);
    @(posedge clk);
    #1 rx_if.src_rdy_n = 1'b1;
  endtask

  task automatic send_word(input string tag, input logic [63:0] d, input logic [2:0] r,
                           input logic [3:0] f);
    rx_if.data = d;
    rx_if.rem  = r;
    {rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = f;
    rx_if.src_rdy_n = 1'b0;
    wait_rx_accept(tag);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    en2    = 1'b1;
    rx_if.data = '0;  rx_if.rem = '0;  rx_if.src_rdy_n = 1'b1;
    {rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = F_SOF;
    rx2_if.data = 64'hA5;  rx2_if.rem = 3'd0;  rx2_if.src_rdy_n = 1'b1;
    {rx2_if.sof_n, rx2_if.eof_n, rx2_if.sop_n, rx2_if.eop_n} = F_ONE;
    tx_if.dst_rdy_n  = 1'b0;
    tx2_if.dst_rdy_n = 1'b0;

    // Reset: handshakes held off even with a valid SOF word present.
    @(posedge clk);
    #1 rx_if.src_rdy_n = 1'b0;
    @(negedge clk);
    check_eq("rst_tx_src", 128'(tx_if.src_rdy_n), 128'h1);
    check_eq("rst_rx_dst", 128'(rx_if.dst_rdy_n), 128'h1);
    @(posedge clk);
    #1 rx_if.src_rdy_n = 1'b1;
    rst = 1'b0;
    check_eq("rst_seq", 128'(seq), 128'h0);
    check_eq("rst_drop", 128'(drop), 128'h0);
    check_eq("rst_seq2", 128'(seq2), 128'hFFFE);

    // 3-word frame with headers enabled.
    send_word("t1_w0", 64'h0123_4567_89AB_CDEF, 3'd7, F_SOF);
    send_word("t1_w1", 64'h1111_0000_2222_0000, 3'd7, F_MID);
    send_word("t1_w2", 64'hDEAD_BEEF_0000_0005, 3'd5, F_EOF);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t1_cnt", 128'(tx_q.size()), 128'd4);
    check_eq("t1_hdr", 128'(tx_q[0]), 128'(mk(hdr(16'h0000), 3'd7, F_HDR)));
    check_eq("t1_b0", 128'(tx_q[1]), 128'(mk(64'h0123_4567_89AB_CDEF, 3'd7, F_SOFX)));
    check_eq("t1_b1", 128'(tx_q[2]), 128'(mk(64'h1111_0000_2222_0000, 3'd7, F_MID)));
    check_eq("t1_b2", 128'(tx_q[3]), 128'(mk(64'hDEAD_BEEF_0000_0005, 3'd5, F_EOF)));
    check_eq("t1_seq", 128'(seq), 128'h1);
    tx_q.delete();

    // Sequence wrap on the second instance: four back-to-back single-word frames.
    rx2_if.src_rdy_n = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx2_if.src_rdy_n = 1'b1;
    check_eq("t2_cnt", 128'(tx2_q.size()), 128'd8);
    check_eq("t2_h0", 128'(tx2_q[0]), 128'(mk(hdr(16'hFFFE), 3'd7, F_HDR)));
    check_eq("t2_d0", 128'(tx2_q[1]), 128'(mk(64'hA5, 3'd0, F_ONEX)));
    check_eq("t2_h1", 128'(tx2_q[2].data), 128'(hdr(16'hFFFF)));
    check_eq("t2_h2", 128'(tx2_q[4].data), 128'(hdr(16'h0000)));
    check_eq("t2_h3", 128'(tx2_q[6].data), 128'(hdr(16'h0001)));
    check_eq("t2_seq", 128'(seq2), 128'h2);

    // Backpressure on the header, then a single-word frame completes.
    tx_if.dst_rdy_n = 1'b1;
    rx_if.data = 64'h1111_2222_3333_4444;
    rx_if.rem  = 3'd3;
    {rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = F_ONE;
    rx_if.src_rdy_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hdr_data", 128'(tx_if.data), 128'(hdr(16'h0001)));
      check_eq("t3_tx_src", 128'(tx_if.src_rdy_n), 128'h0);
      check_eq("t3_rx_dst", 128'(rx_if.dst_rdy_n), 128'h1);
      check_eq("t3_seq_hold", 128'(seq), 128'h1);
    end
    @(posedge clk);
    #1 tx_if.dst_rdy_n = 1'b0;
    wait_rx_accept("t3_w0");
    check_eq("t3_cnt", 128'(tx_q.size()), 128'd2);
    check_eq("t3_hdr", 128'(tx_q[0]), 128'(mk(hdr(16'h0001), 3'd7, F_HDR)));
    check_eq("t3_b0", 128'(tx_q[1]), 128'(mk(64'h1111_2222_3333_4444, 3'd3, F_ONEX)));
    check_eq("t3_seq", 128'(seq), 128'h2);
    tx_q.delete();

    // Headers disabled: bit-identical pass-through; then ENABLE set mid-frame.
    enable = 1'b0;
    send_word("t4_a0", 64'hAAAA_0000_0000_0001, 3'd7, F_SOF);
    send_word("t4_a1", 64'hAAAA_0000_0000_0002, 3'd2, F_EOF);
    send_word("t4_b0", 64'hBBBB_0000_0000_0001, 3'd7, F_SOF);
    enable = 1'b1;
    send_word("t4_b1", 64'hBBBB_0000_0000_0002, 3'd4, F_EOF);
    check_eq("t4_seq_off", 128'(seq), 128'h2);
    send_word("t4_c0", 64'hCCCC_0000_0000_0001, 3'd1, F_ONE);
    repeat (1) @(posedge clk);
    #1;
    check_eq("t4_cnt", 128'(tx_q.size()), 128'd6);
    check_eq("t4_a0", 128'(tx_q[0]), 128'(mk(64'hAAAA_0000_0000_0001, 3'd7, F_SOF)));
    check_eq("t4_a1", 128'(tx_q[1]), 128'(mk(64'hAAAA_0000_0000_0002, 3'd2, F_EOF)));
    check_eq("t4_b0", 128'(tx_q[2]), 128'(mk(64'hBBBB_0000_0000_0001, 3'd7, F_SOF)));
    check_eq("t4_b1", 128'(tx_q[3]), 128'(mk(64'hBBBB_0000_0000_0002, 3'd4, F_EOF)));
    check_eq("t4_hdr", 128'(tx_q[4]), 128'(mk(hdr(16'h0002), 3'd7, F_HDR)));
    check_eq("t4_c0", 128'(tx_q[5]), 128'(mk(64'hCCCC_0000_0000_0001, 3'd1, F_ONEX)));
    check_eq("t4_seq", 128'(seq), 128'h3);
    tx_q.delete();

    // Orphan word between frames, then a normally marked frame.
    d0 = n_drop;
    send_word("t5_orphan", 64'h0BAD_0BAD_0BAD_0BAD, 3'd7, F_MID);
    check_eq("t5_drop_hi", 128'(drop), 128'h1);
    @(posedge clk);
    #1;
    check_eq("t5_drop_lo", 128'(drop), 128'h0);
    check_eq("t5_drop_cnt", 128'(n_drop - d0), 128'd1);
    check_eq("t5_tx_idle", 128'(tx_q.size()), 128'd0);
    send_word("t5_w0", 64'h5555_0000_0000_0001, 3'd6, F_ONE);
    check_eq("t5_hdr", 128'(tx_q[0]), 128'(mk(hdr(16'h0003), 3'd7, F_HDR)));
    check_eq("t5_b0", 128'(tx_q[1]), 128'(mk(64'h5555_0000_0000_0001, 3'd6, F_ONEX)));
    check_eq("t5_seq", 128'(seq), 128'h4);
    tx_q.delete();

    // Reset after word 2 of a 4-word frame; the tail becomes orphans.
    d0 = n_drop;
    send_word("t6_w0", 64'h6666_0000_0000_0000, 3'd7, F_SOF);
    send_word("t6_w1", 64'h6666_0000_0000_0001, 3'd7, F_MID);
    rst = 1'b1;
    rx_if.data = 64'h6666_0000_0000_0002;
    {rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = F_MID;
    rx_if.src_rdy_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_tx_src", 128'(tx_if.src_rdy_n), 128'h1);
    check_eq("t6_rst_rx_dst", 128'(rx_if.dst_rdy_n), 128'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("t6_rst_seq", 128'(seq), 128'h0);
    wait_rx_accept("t6_w2");
    send_word("t6_w3", 64'h6666_0000_0000_0003, 3'd7, F_EOF);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_drop_cnt", 128'(n_drop - d0), 128'd2);
    check_eq("t6_cnt", 128'(tx_q.size()), 128'd3);
    check_eq("t6_hdr", 128'(tx_q[0]), 128'(mk(hdr(16'h0004), 3'd7, F_HDR)));
    check_eq("t6_seq", 128'(seq), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
